// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the draw stages.
// pix_en flows into the generator; all timing signals flow out of it.
interface vga_timing_if;
  logic        pix_en;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  pix_en,
    output hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start, frame_cnt
  );

  modport slave (
    output pix_en,
    input  hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel enable, frame-start strobe and frame counter.
// Sync/blank are decoded from the next counter value so all outputs describe the same pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  vga_io
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic H_ACT = (H_POL != 0);
  localparam logic V_ACT = (V_POL != 0);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_params
      $error("vga_timing_gen: totals must fit 11 bits and sync widths must be nonzero");
    end
  endgenerate

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_wrap   = (hcount_q == 11'(H_TOTAL - 1));
    v_wrap   = (vcount_q == 11'(V_TOTAL - 1));
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
    end
    // 12-bit compares so a boundary equal to 2048 cannot alias to zero
    hblnk_d = ({1'b0, hcount_d} >= 12'(H_ACTIVE));
    hsync_d = (({1'b0, hcount_d} >= 12'(H_ACTIVE + H_FP)) &&
               ({1'b0, hcount_d} <  12'(H_ACTIVE + H_FP + H_SYNC))) ? H_ACT : ~H_ACT;
    vblnk_d = ({1'b0, vcount_d} >= 12'(V_ACTIVE));
    vsync_d = (({1'b0, vcount_d} >= 12'(V_ACTIVE + V_FP)) &&
               ({1'b0, vcount_d} <  12'(V_ACTIVE + V_FP + V_SYNC))) ? V_ACT : ~V_ACT;
    frame_start_d = h_wrap && v_wrap;
    frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~H_ACT;
      hblnk_q       <= 1'b0;
      vsync_q       <= ~V_ACT;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (vga_io.pix_en) begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end else begin
      // Stalled pixel: hold position, but the strobe must not stretch
      frame_start_q <= 1'b0;
    end
  end

  assign vga_io.hcount      = hcount_q;
  assign vga_io.vcount      = vcount_q;
  assign vga_io.hsync       = hsync_q;
  assign vga_io.hblnk       = hblnk_q;
  assign vga_io.vsync       = vsync_q;
  assign vga_io.vblnk       = vblnk_q;
  assign vga_io.frame_start = frame_start_q;
  assign vga_io.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing, inverted-polarity default timing, and a tiny raster
// (16 x 10) used for frame wrap, strobe and mid-frame reset.
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  logic pix_en;
  int   total;
  int   bad;

  vga_timing_if vif_d ();
  vga_timing_if vif_n ();
  vga_timing_if vif_s ();

  assign vif_d.pix_en = pix_en;
  assign vif_n.pix_en = pix_en;
  assign vif_s.pix_en = pix_en;

  vga_timing_gen dut_d (.clk(clk), .rst(rst), .vga_io(vif_d.master));

  vga_timing_gen #(.H_POL(0), .V_POL(0)) dut_n (.clk(clk), .rst(rst), .vga_io(vif_n.master));

  // hsync 10..12, vblnk 6..9, vsync 7..8
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (.clk(clk), .rst(rst), .vga_io(vif_s.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    pix_en = 1'b1;
    #1;
    repeat (3) step();

    chk("rst_hcount",  32'(vif_d.hcount), 32'd0);
    chk("rst_vcount",  32'(vif_d.vcount), 32'd0);
    chk("rst_hsync",   32'(vif_d.hsync), 32'd0);
    chk("rst_vsync",   32'(vif_d.vsync), 32'd0);
    chk("rst_hblnk",   32'(vif_d.hblnk), 32'd0);
    chk("rst_vblnk",   32'(vif_d.vblnk), 32'd0);
    chk("rst_fstart",  32'(vif_d.frame_start), 32'd0);
    chk("rst_fcnt",    32'(vif_d.frame_cnt), 32'd0);
    chk("rst_n_hsync", 32'(vif_n.hsync), 32'd1);
    chk("rst_n_vsync", 32'(vif_n.vsync), 32'd1);

    // One full default line
    rst = 1'b0;
    for (int i = 1; i <= 1056; i++) begin
      step();
      if (i == 1) begin
        chk("l_h1", 32'(vif_d.hcount), 32'd1);
        chk("l_fs1", 32'(vif_d.frame_start), 32'd0);
      end
      if (i == 2) chk("l_h2", 32'(vif_d.hcount), 32'd2);
      if (i == 799) chk("l_hblnk799", 32'(vif_d.hblnk), 32'd0);
      if (i == 800) chk("l_hblnk800", 32'(vif_d.hblnk), 32'd1);
      if (i == 839) begin
        chk("l_hs839", 32'(vif_d.hsync), 32'd0);
        chk("l_nhs839", 32'(vif_n.hsync), 32'd1);
      end
      if (i == 840) begin
        chk("l_hs840", 32'(vif_d.hsync), 32'd1);
        chk("l_nhs840", 32'(vif_n.hsync), 32'd0);
      end
      if (i == 967) begin
        chk("l_hs967", 32'(vif_d.hsync), 32'd1);
        chk("l_nhs967", 32'(vif_n.hsync), 32'd0);
      end
      if (i == 968) begin
        chk("l_hs968", 32'(vif_d.hsync), 32'd0);
        chk("l_nhs968", 32'(vif_n.hsync), 32'd1);
      end
      if (i == 1055) begin
        chk("l_h1055", 32'(vif_d.hcount), 32'd1055);
        chk("l_v1055", 32'(vif_d.vcount), 32'd0);
      end
    end
    chk("l_wrap_h", 32'(vif_d.hcount), 32'd0);
    chk("l_wrap_v", 32'(vif_d.vcount), 32'd1);
    chk("l_wrap_hblnk", 32'(vif_d.hblnk), 32'd0);
    chk("l_wrap_fs", 32'(vif_d.frame_start), 32'd0);

    // pix_en toggling: half-rate line takes 2112 clocks
    for (int j = 0; j < 2112; j++) begin
      pix_en = 1'(j % 2);
      step();
      if (j == 0) chk("pe_hold0", 32'(vif_d.hcount), 32'd0);
      if (j == 1) chk("pe_adv1", 32'(vif_d.hcount), 32'd1);
      if (j == 2) chk("pe_hold2", 32'(vif_d.hcount), 32'd1);
      if (j == 1681) chk("pe_hs841", 32'(vif_d.hsync), 32'd1);
    end
    chk("pe_end_h", 32'(vif_d.hcount), 32'd0);
    chk("pe_end_v", 32'(vif_d.vcount), 32'd2);

    // Reset mid-frame on the default instance, then release into small-raster tests
    pix_en = 1'b1;
    rst    = 1'b1;
    step();
    chk("mr_d_h", 32'(vif_d.hcount), 32'd0);
    chk("mr_d_v", 32'(vif_d.vcount), 32'd0);
    chk("mr_d_hs", 32'(vif_d.hsync), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 161; i++) begin
      step();
      if (i == 10) chk("s_hs10", 32'(vif_s.hsync), 32'd1);
      if (i == 13) chk("s_hs13", 32'(vif_s.hsync), 32'd0);
      if (i == 95) begin
        chk("s_vblnk95", 32'(vif_s.vblnk), 32'd0);
        chk("s_hblnk95", 32'(vif_s.hblnk), 32'd1);
      end
      if (i == 96) begin
        chk("s_vblnk96", 32'(vif_s.vblnk), 32'd1);
        chk("s_vs96", 32'(vif_s.vsync), 32'd0);
      end
      if (i == 112) chk("s_vs112", 32'(vif_s.vsync), 32'd1);
      if (i == 143) chk("s_vs143", 32'(vif_s.vsync), 32'd1);
      if (i == 144) begin
        chk("s_vs144", 32'(vif_s.vsync), 32'd0);
        chk("s_vblnk144", 32'(vif_s.vblnk), 32'd1);
      end
      if (i == 159) begin
        chk("s_fs159", 32'(vif_s.frame_start), 32'd0);
        chk("s_fc159", 32'(vif_s.frame_cnt), 32'd0);
      end
      if (i == 160) begin
        chk("s_fs160", 32'(vif_s.frame_start), 32'd1);
        chk("s_fc160", 32'(vif_s.frame_cnt), 32'd1);
        chk("s_h160", 32'(vif_s.hcount), 32'd0);
        chk("s_v160", 32'(vif_s.vcount), 32'd0);
        chk("s_vblnk160", 32'(vif_s.vblnk), 32'd0);
      end
    end
    chk("s_fs161", 32'(vif_s.frame_start), 32'd0);
    chk("s_fc161", 32'(vif_s.frame_cnt), 32'd1);
    chk("s_h161", 32'(vif_s.hcount), 32'd1);

    // Second frame boundary, then stall right on the strobe cycle
    repeat (159) step();
    chk("s_fs320", 32'(vif_s.frame_start), 32'd1);
    chk("s_fc320", 32'(vif_s.frame_cnt), 32'd2);
    pix_en = 1'b0;
    step();
    chk("s_stall_fs", 32'(vif_s.frame_start), 32'd0);
    chk("s_stall_h", 32'(vif_s.hcount), 32'd0);
    chk("s_stall_fc", 32'(vif_s.frame_cnt), 32'd2);
    pix_en = 1'b1;
    step();
    chk("s_resume_h", 32'(vif_s.hcount), 32'd1);
    chk("s_resume_fs", 32'(vif_s.frame_start), 32'd0);

    // Walk to (v=3, h=4), then a 1-cycle reset
    repeat (51) step();
    chk("s_pre_h", 32'(vif_s.hcount), 32'd4);
    chk("s_pre_v", 32'(vif_s.vcount), 32'd3);
    rst = 1'b1;
    step();
    chk("s_mr_h", 32'(vif_s.hcount), 32'd0);
    chk("s_mr_v", 32'(vif_s.vcount), 32'd0);
    chk("s_mr_fc", 32'(vif_s.frame_cnt), 32'd0);
    chk("s_mr_fs", 32'(vif_s.frame_start), 32'd0);
    chk("s_mr_hs", 32'(vif_s.hsync), 32'd0);
    chk("s_mr_vs", 32'(vif_s.vsync), 32'd0);
    rst = 1'b0;
    step();
    chk("s_rel_h", 32'(vif_s.hcount), 32'd1);
    chk("s_rel_fs", 32'(vif_s.frame_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
